branch_cmp_arb: RTL and testbench
=================================

BRANCH_CMP_ARB -- requirements
Module: branch_cmp_arb

Parameters
REQ-001 The block SHALL provide parameter NUM_REQ, default 4, meaning the number of requesters sharing the single branch comparator (legal range 2..8).
REQ-002 The block SHALL provide parameter ROB_IDX_W, default 5, meaning the width of the reorder-buffer tag carried with each request.

Interface
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 flush  input  1  pipeline flush; kills the pending result and blocks grants this cycle.
REQ-006 req_valid  input  NUM_REQ  per-requester request valid.
REQ-007 req_ready  output  NUM_REQ  per-requester grant; combinational, one-hot or zero.
REQ-008 req_cmpop  input  NUM_REQ x 3  per-requester funct3 compare op.
REQ-009 req_a, req_b  input  NUM_REQ x 32  per-requester operands.
REQ-010 req_pc, req_target  input  NUM_REQ x 32  per-requester branch PC and taken target.
REQ-011 req_rob  input  NUM_REQ x ROB_IDX_W  per-requester ROB tag.
REQ-012 res_valid  output  1  registered result valid.
REQ-013 res_ready  input  1  consumer accepts the result.
REQ-014 res_taken, res_next_pc, res_rob, res_src  output  1 / 32 / ROB_IDX_W / clog2(NUM_REQ)  outcome, next PC, tag, and granted requester index.

Function
REQ-015 Compare encodings SHALL be: 000 beq, 001 bne, 100 blt (signed), 101 bge (signed), 110 bltu, 111 bgeu; codes 010 and 011 SHALL produce taken=0.
REQ-016 A handshake on requester i SHALL occur when req_valid[i] and req_ready[i] are both 1; the request is consumed in that cycle.
REQ-017 can_accept SHALL equal (!res_valid || res_ready) && !flush && !rst.
REQ-018 When can_accept is 1, req_ready SHALL grant exactly one valid requester, chosen round-robin starting from priority pointer ptr and scanning ptr, ptr+1, ... modulo NUM_REQ; when can_accept is 0, req_ready SHALL be all zeros.
REQ-019 After a grant to index g, ptr SHALL become (g+1) mod NUM_REQ; without a grant, ptr SHALL be unchanged.
REQ-020 On a grant, the next cycle SHALL present res_valid=1, res_taken=cmp(op,a,b), res_next_pc = taken ? req_target : req_pc+4 (mod 2^32), res_rob=req_rob[g], res_src=g; latency is one cycle from handshake to res_valid.
REQ-021 res_valid=1 with res_ready=0 SHALL hold all res_* outputs stable.
REQ-022 res_valid=1 with res_ready=1 and a new grant in the same cycle SHALL load the new result back-to-back, sustaining one result per cycle.
REQ-023 res_valid=1 with res_ready=1 and no grant SHALL clear res_valid next cycle.
REQ-024 flush=1 SHALL clear res_valid next cycle regardless of res_ready, grant nothing, and leave ptr unchanged.
REQ-025 The outputs res_taken, res_next_pc, res_rob, and res_src are don't-care while res_valid=0.

Reset
REQ-026 While rst=1: req_ready=0, and on the edge res_valid becomes 0, ptr becomes 0, and res_taken, res_next_pc, res_rob, and res_src become 0.
REQ-027 Reset SHALL override flush and any in-flight result; the first grant after reset SHALL consider requester 0 first.

Verification
REQ-028 Reset, then req_valid=4'b1111 with res_ready=1 for 4 cycles -> grants go to 0, 1, 2, 3 in order, with one res_valid per cycle matching res_src.
REQ-029 Requester 2 issues blt with a=0xFFFFFFFF, b=1, pc=0x100, target=0x200 -> res_taken=1, res_next_pc=0x200; the same operands with bltu -> res_taken=0, res_next_pc=0x104.
REQ-030 Result valid and res_ready=0 for 3 cycles while requesters are valid -> req_ready=0 and res_* stable; when res_ready rises, a new grant occurs in the same cycle.
REQ-031 flush asserted while res_valid=1 and req_valid=4'b0010 -> next cycle res_valid=0, no grant that cycle, and ptr unchanged.
REQ-032 pc=0xFFFFFFFC, not taken (beq with a=1, b=2) -> res_next_pc=0x00000000 (wrap-around).
REQ-033 rst asserted mid-stream with res_valid=1 and res_ready=0 -> next cycle res_valid=0 and ptr=0; op 3'b010 with a=b -> res_taken=0.

Source files
------------

// File: rtl/branch_cmp_arb_if.sv
// branch_cmp_arb_if
//   Bundles the requester-side and result-side signals of the shared branch
//   comparator. The requester/consumer environment uses the master modport and
//   the arbiter uses the slave modport.
//
//   Handshake rule, used on both sides: a transfer happens in the cycle where
//   valid and ready are both 1 at the rising edge of clk. The request side
//   (req_valid[i]/req_ready[i]) is consumed in that cycle. The result side
//   (res_valid/res_ready) is retired in that cycle. A valid source holds its
//   payload stable until the transfer occurs.
//
//   Signals
//     req_valid   [NUM_REQ]          per-requester request valid
//     req_ready   [NUM_REQ]          per-requester grant (one-hot or zero)
//     req_cmpop   [NUM_REQ][3]       funct3 compare op
//     req_a/b     [NUM_REQ][32]      operands
//     req_pc      [NUM_REQ][32]      branch PC
//     req_target  [NUM_REQ][32]      taken target
//     req_rob     [NUM_REQ][ROB]     reorder-buffer tag
//     res_valid/res_ready            result handshake
//     res_taken, res_next_pc, res_rob, res_src   result payload
interface branch_cmp_arb_if #(
  parameter int NUM_REQ   = 4,
  parameter int ROB_IDX_W = 5
);
  localparam int SRC_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0]                req_ready;
  logic [NUM_REQ-1:0][2:0]           req_cmpop;
  logic [NUM_REQ-1:0][31:0]          req_a;
  logic [NUM_REQ-1:0][31:0]          req_b;
  logic [NUM_REQ-1:0][31:0]          req_pc;
  logic [NUM_REQ-1:0][31:0]          req_target;
  logic [NUM_REQ-1:0][ROB_IDX_W-1:0] req_rob;

  logic                 res_valid;
  logic                 res_ready;
  logic                 res_taken;
  logic [31:0]          res_next_pc;
  logic [ROB_IDX_W-1:0] res_rob;
  logic [SRC_W-1:0]     res_src;

  modport master (
    output req_valid, req_cmpop, req_a, req_b, req_pc, req_target, req_rob,
    input  req_ready,
    input  res_valid, res_taken, res_next_pc, res_rob, res_src,
    output res_ready
  );

  modport slave (
    input  req_valid, req_cmpop, req_a, req_b, req_pc, req_target, req_rob,
    output req_ready,
    output res_valid, res_taken, res_next_pc, res_rob, res_src,
    input  res_ready
  );
endinterface

// File: rtl/branch_cmp_arb.sv
// branch_cmp_arb
//   Shares one branch comparator between NUM_REQ requesters. Each cycle a
//   round-robin arbiter grants at most one valid requester, starting the scan
//   at priority pointer ptr. The granted request is compared and its outcome is
//   registered into a single result slot, presented one cycle later.
//
//   Ports
//     clk      rising-edge clock
//     rst      synchronous active-high reset
//     flush    kills the pending result and blocks grants this cycle
//     bus      branch_cmp_arb_if.slave (request and result handshakes)
//     dbg_ptr  current round-robin priority pointer
module branch_cmp_arb #(
  parameter int NUM_REQ   = 4,
  parameter int ROB_IDX_W = 5,
  localparam int SRC_W    = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  branch_cmp_arb_if.slave  bus,
  output logic [SRC_W-1:0] dbg_ptr
);

  localparam logic [SRC_W:0]   NUM_REQ_W = (SRC_W+1)'(NUM_REQ);
  localparam logic [SRC_W-1:0] LAST_IDX  = SRC_W'(NUM_REQ - 1);

  // Branch compare on funct3; codes 010/011 are not branches and never taken.
  function automatic logic cmp_taken(input logic [2:0] op,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
    case (op)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) <  $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a <  b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  logic [SRC_W-1:0]     ptr;
  logic                 res_valid_q;
  logic                 res_taken_q;
  logic [31:0]          res_next_pc_q;
  logic [ROB_IDX_W-1:0] res_rob_q;
  logic [SRC_W-1:0]     res_src_q;

  logic                 can_accept;
  logic [NUM_REQ-1:0]   grant;
  logic                 grant_found;
  logic [SRC_W-1:0]     grant_idx;
  logic [SRC_W:0]       scan_sum;
  logic [SRC_W-1:0]     scan_idx;
  logic [SRC_W-1:0]     ptr_next;
  logic                 new_taken;

  // The single result slot can take a new entry when empty or being drained.
  assign can_accept = (!res_valid_q || bus.res_ready) && !flush && !rst;

  // Round-robin scan: ptr, ptr+1, ... modulo NUM_REQ. ptr and the offset are
  // both below NUM_REQ, so one conditional subtraction performs the wrap.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, ptr} + (SRC_W+1)'(k);
      if (scan_sum >= NUM_REQ_W) begin
        scan_sum = scan_sum - NUM_REQ_W;
      end
      scan_idx = scan_sum[SRC_W-1:0];
      if (can_accept && !grant_found && bus.req_valid[scan_idx]) begin
        grant_found     = 1'b1;
        grant_idx       = scan_idx;
        grant[scan_idx] = 1'b1;
      end
    end
  end

  assign ptr_next  = (grant_idx == LAST_IDX) ? '0 : grant_idx + SRC_W'(1);
  assign new_taken = cmp_taken(bus.req_cmpop[grant_idx], bus.req_a[grant_idx],
                               bus.req_b[grant_idx]);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr           <= '0;
      res_valid_q   <= 1'b0;
      res_taken_q   <= 1'b0;
      res_next_pc_q <= '0;
      res_rob_q     <= '0;
      res_src_q     <= '0;
    end else if (flush) begin
      res_valid_q <= 1'b0;
    end else if (grant_found) begin
      ptr           <= ptr_next;
      res_valid_q   <= 1'b1;
      res_taken_q   <= new_taken;
      res_next_pc_q <= new_taken ? bus.req_target[grant_idx]
                                 : bus.req_pc[grant_idx] + 32'd4;
      res_rob_q     <= bus.req_rob[grant_idx];
      res_src_q     <= grant_idx;
    end else if (bus.res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  assign bus.req_ready   = grant;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_taken   = res_taken_q;
  assign bus.res_next_pc = res_next_pc_q;
  assign bus.res_rob     = res_rob_q;
  assign bus.res_src     = res_src_q;
  assign dbg_ptr         = ptr;

endmodule

// File: tb/tb_branch_cmp_arb.sv
module tb_branch_cmp_arb;
  localparam int NUM_REQ   = 4;
  localparam int ROB_IDX_W = 5;
  localparam int SRC_W     = 2;
  localparam int RW        = 1 + 32 + ROB_IDX_W + SRC_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic [SRC_W-1:0] dbg_ptr;

  always #5 clk = ~clk;

  branch_cmp_arb_if #(.NUM_REQ(NUM_REQ), .ROB_IDX_W(ROB_IDX_W)) bus ();

  branch_cmp_arb #(.NUM_REQ(NUM_REQ), .ROB_IDX_W(ROB_IDX_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .bus     (bus),
    .dbg_ptr (dbg_ptr)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [RW-1:0] exp_q[$];   // results granted but not yet retired
  int m_ptr = 0;             // model round-robin pointer

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference compare straight from the funct3 table.
  function automatic logic ref_taken(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return {32'd0, a} < {32'd0, b};
      3'd7: return {32'd0, a} >= {32'd0, b};
      default: return 1'b0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic [ROB_IDX_W-1:0] rob);
    bus.req_cmpop[i]  = op;
    bus.req_a[i]      = a;
    bus.req_b[i]      = b;
    bus.req_pc[i]     = pc;
    bus.req_target[i] = tgt;
    bus.req_rob[i]    = rob;
  endtask

  task automatic rand_reqs();
    logic [31:0] a;
    for (int i = 0; i < NUM_REQ; i++) begin
      a = $urandom;
      set_req(i, 3'($urandom_range(0, 7)), a,
              ($urandom_range(0, 3) == 0) ? a : 32'($urandom),
              {$urandom_range(0, 32'h3FFFFFFF), 2'b00}, 32'($urandom),
              ROB_IDX_W'($urandom_range(0, 31)));
    end
  endtask

  // One clock cycle: inputs were set at the falling edge. Check combinational
  // grant and registered outputs against the model, advance the model, clock.
  task automatic cycle();
    int g;
    int j;
    logic [NUM_REQ-1:0] exp_ready;
    logic [RW-1:0] word;
    logic tk;
    #1;
    g = -1;
    if ((exp_q.size() == 0 || bus.res_ready) && !flush && !rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        j = (m_ptr + i) % NUM_REQ;
        if (g < 0 && bus.req_valid[j]) g = j;
      end
    end
    exp_ready = (g >= 0) ? NUM_REQ'(1 << g) : '0;
    check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    check("ptr", 64'(dbg_ptr), 64'(m_ptr));
    check("res_valid", 64'(bus.res_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0)
      check("res_payload",
            64'({bus.res_taken, bus.res_next_pc, bus.res_rob, bus.res_src}),
            64'(exp_q[0]));
    if (rst) begin
      exp_q.delete();
      m_ptr = 0;
    end else if (flush) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() != 0 && bus.res_ready) void'(exp_q.pop_front());
      if (g >= 0) begin
        tk = ref_taken(bus.req_cmpop[g], bus.req_a[g], bus.req_b[g]);
        word = {tk, tk ? bus.req_target[g] : bus.req_pc[g] + 32'd4,
                bus.req_rob[g], SRC_W'(g)};
        exp_q.push_back(word);
        m_ptr = (g + 1) % NUM_REQ;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst           = 1'b1;
    flush         = 1'b0;
    bus.req_valid = '0;
    bus.res_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 3'd0, 0, 0, 0, 0, 0);
    @(negedge clk);
    cycle();
    cycle();

    // Reset state
    check("rst_valid", 64'(bus.res_valid), 64'd0);
    check("rst_payload", 64'({bus.res_taken, bus.res_next_pc, bus.res_rob, bus.res_src}), 64'd0);
    check("rst_ptr", 64'(dbg_ptr), 64'd0);
    rst = 1'b0;

    // All four requesting: grants rotate 0,1,2,3
    rand_reqs();
    bus.req_valid = 4'b1111;
    bus.res_ready = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) begin
      cycle();
      check("rr_src", 64'(bus.res_src), 64'(k));
    end

    // Signed vs unsigned less-than on requester 2
    bus.req_valid = 4'b0100;
    set_req(2, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h200, 5'd7);
    cycle();
    check("blt_taken", 64'(bus.res_taken), 64'd1);
    check("blt_pc", 64'(bus.res_next_pc), 64'h200);
    set_req(2, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h200, 5'd7);
    cycle();
    check("bltu_taken", 64'(bus.res_taken), 64'd0);
    check("bltu_pc", 64'(bus.res_next_pc), 64'h104);

    // Back-pressure: result held 3 cycles, then grant on release
    rand_reqs();
    bus.req_valid = 4'b1111;
    bus.res_ready = 1'b0;
    repeat (3) cycle();
    bus.res_ready = 1'b1;
    cycle();
    check("bp_valid_after", 64'(bus.res_valid), 64'd1);

    // Flush with a live result
    flush = 1'b1;
    bus.req_valid = 4'b0010;
    bus.res_ready = 1'b0;
    cycle();
    flush = 1'b0;
    bus.req_valid = '0;
    check("flush_valid", 64'(bus.res_valid), 64'd0);
    cycle();

    // PC wrap-around on not-taken
    bus.req_valid = 4'b0001;
    bus.res_ready = 1'b1;
    set_req(0, 3'b000, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'h40, 5'd3);
    cycle();
    check("wrap_pc", 64'(bus.res_next_pc), 64'd0);

    // Reset mid-stream with a stalled result
    bus.res_ready = 1'b0;
    bus.req_valid = 4'b1111;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("mid_rst_valid", 64'(bus.res_valid), 64'd0);
    check("mid_rst_ptr", 64'(dbg_ptr), 64'd0);
    bus.req_valid = 4'b0001;
    bus.res_ready = 1'b1;
    set_req(0, 3'b010, 32'h55, 32'h55, 32'h1000, 32'h2000, 5'd9);
    cycle();
    check("op010_taken", 64'(bus.res_taken), 64'd0);
    check("op010_src", 64'(bus.res_src), 64'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rand_reqs();
      bus.req_valid = NUM_REQ'($urandom_range(0, 15));
      bus.res_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 19) == 0);
      rst   = ($urandom_range(0, 49) == 0);
      cycle();
    end
    rst = 1'b0;
    flush = 1'b0;

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
